// File: rtl/sync_fifo_rr_sched.sv
// Round-robin dequeue scheduler: shares one valid/ready output stream between
// NUM_QUEUES standard-mode sync FIFOs, serving bursts of up to BURST_MAX words.
module sync_fifo_rr_sched #(
    parameter int NUM_QUEUES = 4,
    parameter int WIDTH      = 32,
    parameter int BURST_MAX  = 4,
    parameter int QID_W      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_QUEUES-1:0]       i_queue_en,
    input  logic [NUM_QUEUES-1:0]       i_fifo_empty,
    output logic [NUM_QUEUES-1:0]       o_fifo_rd_en,
    input  logic [NUM_QUEUES*WIDTH-1:0] i_fifo_dout,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [WIDTH-1:0]            o_data,
    output logic [QID_W-1:0]            o_qid,
    output logic                        o_busy
);

    typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

    state_t                  state;
    logic [QID_W-1:0]        grant;
    logic [QID_W-1:0]        last_grant;
    logic [QID_W-1:0]        next_grant;
    logic [7:0]              burst_cnt;
    logic [7:0]              burst_nxt;
    logic [NUM_QUEUES-1:0]   eligible;
    logic                    found;
    logic                    grant_ok;
    logic [WIDTH-1:0]        dout_sel;

    assign eligible  = ~i_fifo_empty & i_queue_en;
    assign burst_nxt = burst_cnt + 8'd1;
    assign o_busy    = (state != IDLE);

    // Search upward from last_grant+1; wrap is explicit since NUM_QUEUES need not be a power of 2.
    always_comb begin
        int idx;
        idx        = 0;
        next_grant = '0;
        found      = 1'b0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                next_grant = QID_W'(idx);
            end
        end
    end

    always_comb begin
        dout_sel     = '0;
        grant_ok     = 1'b0;
        o_fifo_rd_en = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            if (grant == QID_W'(k)) begin
                dout_sel        = i_fifo_dout[k*WIDTH +: WIDTH];
                grant_ok        = eligible[k];
                o_fifo_rd_en[k] = (state == RD);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= QID_W'(NUM_QUEUES - 1);
            burst_cnt  <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_qid      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= next_grant;
                        burst_cnt <= '0;
                        state     <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    o_data  <= dout_sel;
                    o_qid   <= grant;
                    o_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        burst_cnt <= burst_nxt;
                        // Empty flag checked this cycle covers the next read on the same queue.
                        if (burst_nxt < 8'(BURST_MAX) && grant_ok) begin
                            state <= RD;
                        end else begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
